// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - execute-stage multiply/divide unit with architectural HI/LO
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        StartE,
    input  logic [2:0]  MDOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        MDStall
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] phi_q, plo_q;
    logic        pcommit_q;
    logic        busy_q;

    logic        is_mul, is_div, is_md;
    logic        a_neg, b_neg, div_signed;
    logic [31:0] a_mag, b_mag, divd, dvsr, q_u, r_u;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] phi_d, plo_d;
    logic        pcommit_d;
    logic [3:0]  cnt_d;

    assign is_mul = (MDOpE == OP_MULT) || (MDOpE == OP_MULTU);
    assign is_div = (MDOpE == OP_DIV)  || (MDOpE == OP_DIVU);
    assign is_md  = is_mul || is_div;

    // Result datapath: one wide multiplier, one unsigned divider shared by DIV/DIVU via sign-magnitude
    always_comb begin
        a_neg      = SrcAE[31];
        b_neg      = SrcBE[31];
        div_signed = (MDOpE == OP_DIV);
        a_mag      = a_neg ? (32'd0 - SrcAE) : SrcAE;
        b_mag      = b_neg ? (32'd0 - SrcBE) : SrcBE;
        divd       = div_signed ? a_mag : SrcAE;
        dvsr       = div_signed ? b_mag : SrcBE;
        q_u        = (dvsr == 32'd0) ? 32'd0 : (divd / dvsr);
        r_u        = (dvsr == 32'd0) ? 32'd0 : (divd % dvsr);

        // Sign-extending to 64 bits makes the low 64 bits of the product correct for MULT
        if (MDOpE == OP_MULT) begin
            mul_a = {{32{SrcAE[31]}}, SrcAE};
            mul_b = {{32{SrcBE[31]}}, SrcBE};
        end else begin
            mul_a = {32'd0, SrcAE};
            mul_b = {32'd0, SrcBE};
        end
        product = mul_a * mul_b;

        phi_d     = 32'd0;
        plo_d     = 32'd0;
        pcommit_d = 1'b1;
        cnt_d     = 4'(MULT_CYCLES - 1);
        if (is_mul) begin
            phi_d = product[63:32];
            plo_d = product[31:0];
        end else begin
            cnt_d     = 4'(DIV_CYCLES - 1);
            // A zero divisor still burns the full latency but leaves HI/LO untouched
            pcommit_d = (SrcBE != 32'd0);
            if (div_signed) begin
                plo_d = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
                phi_d = a_neg ? (32'd0 - r_u) : r_u;
            end else begin
                plo_d = q_u;
                phi_d = r_u;
            end
        end
    end

    // Control FSM with registered Busy, shadow result and architectural HI/LO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            phi_q     <= 32'd0;
            plo_q     <= 32'd0;
            pcommit_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (StartE && is_md) begin
                        phi_q     <= phi_d;
                        plo_q     <= plo_d;
                        pcommit_q <= pcommit_d;
                        cnt_q     <= cnt_d;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else if (StartE && (MDOpE == OP_MTHI)) begin
                        hi_q <= SrcAE;
                    end else if (StartE && (MDOpE == OP_MTLO)) begin
                        lo_q <= SrcAE;
                    end
                end
                RUN: begin
                    // Anything presented on StartE here is ignored; the hazard unit prevents it
                    if (cnt_q == 4'd0) begin
                        if (pcommit_q) begin
                            hi_q <= phi_q;
                            lo_q <= plo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign HI      = hi_q;
    assign LO      = lo_q;
    assign Busy    = busy_q;
    // Asserted in the start cycle too, so a following MD instruction in D stalls without a gap
    assign MDStall = busy_q | (StartE & is_md);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit
module tb_mul_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        StartE;
    logic [2:0]  MDOpE;
    logic [31:0] SrcAE, SrcBE;
    logic [31:0] HI, LO;
    logic        Busy, MDStall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] hi_m, lo_m;

    mul_div_unit dut (
        .clk(clk), .reset_n(reset_n), .StartE(StartE), .MDOpE(MDOpE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .HI(HI), .LO(LO), .Busy(Busy), .MDStall(MDStall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Architectural reference: plain 64-bit integer arithmetic
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0]     bits;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT: begin
                bits = sa * sb;
                hi_m = bits[63:32]; lo_m = bits[31:0];
            end
            OP_MULTU: begin
                p = ua * ub;
                bits = p;
                hi_m = bits[63:32]; lo_m = bits[31:0];
            end
            OP_DIV: if (b != 32'd0) begin
                q = sa / sb; r = sa % sb;
                bits = q; lo_m = bits[31:0];
                bits = r; hi_m = bits[31:0];
            end
            OP_DIVU: if (b != 32'd0) begin
                p = ua / ub; bits = p; lo_m = bits[31:0];
                p = ua % ub; bits = p; hi_m = bits[31:0];
            end
            default: ;
        endcase
    endtask

    // mode 0: quiet operands, 1: scramble operands during RUN, 2: issue MTLO 0xAAAA during RUN
    task automatic md_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
        int n, exp_n;
        logic [31:0] hi_old, lo_old;
        @(negedge clk);
        StartE = 1'b1; MDOpE = op; SrcAE = a; SrcBE = b;
        #1 check_eq("mdstall_start", MDStall, 1);
        hi_old = hi_m; lo_old = lo_m;
        model(op, a, b);
        exp_n = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
        @(negedge clk);
        StartE = 1'b0; MDOpE = 3'b000;
        n = 0;
        while (Busy && n < 40) begin
            n++;
            check_eq("stale_hi", HI, hi_old);
            check_eq("stale_lo", LO, lo_old);
            check_eq("mdstall_run", MDStall, 1);
            if (mode == 1) begin
                SrcAE = $urandom; SrcBE = $urandom;
            end
            if (mode == 2) begin
                if (n == 1) begin
                    $display("warning: MTLO issued while MD unit busy (expected to be ignored)");
                    StartE = 1'b1; MDOpE = OP_MTLO; SrcAE = 32'h0000AAAA;
                end else begin
                    StartE = 1'b0; MDOpE = 3'b000;
                end
            end
            @(negedge clk);
        end
        StartE = 1'b0; MDOpE = 3'b000;
        check_eq("busy_len", n, exp_n);
        check_eq("hi_result", HI, hi_m);
        check_eq("lo_result", LO, lo_m);
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        StartE = 1'b1; MDOpE = op; SrcAE = v; SrcBE = $urandom;
        #1 check_eq("mdstall_mt", MDStall, 0);
        if (op == OP_MTHI) hi_m = v; else lo_m = v;
        @(negedge clk);
        StartE = 1'b0; MDOpE = 3'b000;
        check_eq("mt_busy", Busy, 0);
        check_eq("mt_hi", HI, hi_m);
        check_eq("mt_lo", LO, lo_m);
    endtask

    task automatic nop_op(input logic [2:0] op);
        @(negedge clk);
        StartE = 1'b1; MDOpE = op; SrcAE = $urandom; SrcBE = $urandom;
        #1 check_eq("mdstall_nop", MDStall, 0);
        @(negedge clk);
        StartE = 1'b0; MDOpE = 3'b000;
        check_eq("nop_busy", Busy, 0);
        check_eq("nop_hi", HI, hi_m);
        check_eq("nop_lo", LO, lo_m);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [8];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFFFFFF; c[3] = 32'h80000000;
        c[4] = 32'h7FFFFFFF; c[5] = 32'h2; c[6] = 32'hFFFFFFFE; c[7] = 32'h10000;
        if ($urandom_range(0, 2) == 0) return c[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 0) return $urandom_range(0, 1000);
        return $urandom;
    endfunction

    initial begin
        reset_n = 1'b0; StartE = 1'b0; MDOpE = 3'b000; SrcAE = 32'd0; SrcBE = 32'd0;
        hi_m = 32'd0; lo_m = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_hi", HI, 0);
        check_eq("reset_lo", LO, 0);
        check_eq("reset_busy", Busy, 0);
        check_eq("reset_mdstall", MDStall, 0);
        reset_n = 1'b1;

        md_op(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 0);
        check_eq("t1_hi", HI, 32'h00000001);
        check_eq("t1_lo", LO, 32'hFFFFFFFE);
        md_op(OP_MULT, 32'hFFFFFFFD, 32'h00000004, 1);
        check_eq("t2_hi", HI, 32'hFFFFFFFF);
        check_eq("t2_lo", LO, 32'hFFFFFFF4);
        md_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 0);
        check_eq("t3_lo", LO, 32'hFFFFFFFD);
        check_eq("t3_hi", HI, 32'hFFFFFFFF);
        md_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
        check_eq("t3b_lo", LO, 32'h80000000);
        check_eq("t3b_hi", HI, 32'h00000000);
        mt_op(OP_MTHI, 32'h12345678);
        md_op(OP_DIVU, 32'hDEADBEEF, 32'h0, 0);
        check_eq("t4_hi", HI, 32'h12345678);
        check_eq("t4_lo", LO, 32'h80000000);
        nop_op(3'b000);
        nop_op(3'b111);

        // Reset in the middle of a DIVU must discard the pending result
        @(negedge clk);
        StartE = 1'b1; MDOpE = OP_DIVU; SrcAE = 32'd1000; SrcBE = 32'd7;
        @(negedge clk);
        StartE = 1'b0; MDOpE = 3'b000;
        repeat (3) @(negedge clk);
        check_eq("t5_busy_before", Busy, 1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_hi", HI, 0);
        check_eq("t5_lo", LO, 0);
        check_eq("t5_busy", Busy, 0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("t5_late_hi", HI, 0);
        check_eq("t5_late_lo", LO, 0);
        check_eq("t5_late_busy", Busy, 0);

        md_op(OP_MULT, 32'h00001234, 32'hFFFF0001, 2);
        check_eq("t6_lo_not_aaaa", (LO == 32'h0000AAAA), 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 6) md_op(3'($urandom_range(1, 4)), pick(), pick(), int'($urandom_range(0, 1)));
            else if (r == 7) mt_op($urandom_range(0, 1) ? OP_MTHI : OP_MTLO, $urandom);
            else if (r == 8) md_op(3'($urandom_range(3, 4)), $urandom, 32'd0, 1);
            else nop_op($urandom_range(0, 1) ? 3'b000 : 3'b111);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
